// File: rtl/lookup3_hash.sv
// rtl/lookup3_hash.sv - Jenkins lookup3 hashlittle engine over a 32-bit word stream
//
// Hashes a little-endian byte message of len bytes, seeded by initval, and
// returns the lookup3 value c.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   res        asynchronous active-low reset
//   start      request a new hash (taken only while busy=0)
//   len        message length in bytes, sampled with start
//   initval    32-bit seed, sampled with start
//   in_valid   in_data holds a message word
//   in_data    message word, byte n in bits [8n+7:8n]
//   in_ready   block takes in_data this cycle
//   busy       hash in progress or result not yet taken
//   out_valid  out_hash valid, held until out_ready
//   out_ready  consumer takes out_hash
//   out_hash   hash result
//
// UNROLL=1 runs a whole mix/final per cycle; UNROLL=0 runs one round per cycle.
module lookup3_hash #(
  parameter int LEN_W  = 16,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      initval,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_hash
);

  typedef enum logic [2:0] {IDLE, LOAD, MIX, TAIL, FINAL, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_c;
  logic [LEN_W-1:0] r_rem;
  logic [1:0]       r_widx;
  logic [2:0]       r_rnd;

  logic [95:0]      w_mix_all;
  logic [95:0]      w_fin_all;
  logic [95:0]      w_mix_sel;
  logic [95:0]      w_fin_sel;
  logic             w_mix_last;
  logic             w_fin_last;
  logic [LEN_W-1:0] w_left;
  logic [LEN_W-1:0] w_rem_dec;
  logic             w_last_word;
  logic [31:0]      w_mask;
  logic [31:0]      w_word;
  logic [31:0]      w_init;
  logic             w_xfer;

  function automatic logic [31:0] rot(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // One of the six mix rounds; state packed as {a,b,c}.
  function automatic logic [95:0] mix_round(input logic [95:0] s, input logic [2:0] r);
    logic [31:0] a, b, c;
    {a, b, c} = s;
    case (r)
      3'd0:    begin a = (a - c) ^ rot(c, 4);  c = c + b; end
      3'd1:    begin b = (b - a) ^ rot(a, 6);  a = a + c; end
      3'd2:    begin c = (c - b) ^ rot(b, 8);  b = b + a; end
      3'd3:    begin a = (a - c) ^ rot(c, 16); c = c + b; end
      3'd4:    begin b = (b - a) ^ rot(a, 19); a = a + c; end
      default: begin c = (c - b) ^ rot(b, 4);  b = b + a; end
    endcase
    return {a, b, c};
  endfunction

  // One of the seven final rounds; state packed as {a,b,c}.
  function automatic logic [95:0] fin_round(input logic [95:0] s, input logic [2:0] r);
    logic [31:0] a, b, c;
    {a, b, c} = s;
    case (r)
      3'd0:    c = (c ^ b) - rot(b, 14);
      3'd1:    a = (a ^ c) - rot(c, 11);
      3'd2:    b = (b ^ a) - rot(a, 25);
      3'd3:    c = (c ^ b) - rot(b, 16);
      3'd4:    a = (a ^ c) - rot(c, 4);
      3'd5:    b = (b ^ a) - rot(a, 14);
      default: c = (c ^ b) - rot(b, 24);
    endcase
    return {a, b, c};
  endfunction

  always_comb begin
    w_mix_all = {r_a, r_b, r_c};
    for (int i = 0; i < 6; i++) w_mix_all = mix_round(w_mix_all, 3'(i));
    w_fin_all = {r_a, r_b, r_c};
    for (int i = 0; i < 7; i++) w_fin_all = fin_round(w_fin_all, 3'(i));
  end

  assign w_mix_sel  = (UNROLL != 0) ? w_mix_all : mix_round({r_a, r_b, r_c}, r_rnd);
  assign w_fin_sel  = (UNROLL != 0) ? w_fin_all : fin_round({r_a, r_b, r_c}, r_rnd);
  assign w_mix_last = (UNROLL != 0) || (r_rnd == 3'd5);
  assign w_fin_last = (UNROLL != 0) || (r_rnd == 3'd6);

  // Bytes of the message still covered by the current tail word onward.
  assign w_left      = r_rem - LEN_W'({r_widx, 2'b00});
  assign w_last_word = (w_left <= LEN_W'(4));
  assign w_rem_dec   = r_rem - LEN_W'(12);

  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    if (w_left < LEN_W'(4)) begin
      case (w_left[1:0])
        2'd1:    w_mask = 32'h0000_00FF;
        2'd2:    w_mask = 32'h0000_FFFF;
        2'd3:    w_mask = 32'h00FF_FFFF;
        default: w_mask = 32'h0000_0000;
      endcase
    end
  end

  assign w_word = (r_state == TAIL) ? (in_data & w_mask) : in_data;
  assign w_init = 32'hDEAD_BEEF + 32'(len) + initval;
  assign w_xfer = in_valid && in_ready;

  assign in_ready  = (r_state == LOAD) || (r_state == TAIL);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign out_hash  = out_valid ? r_c : 32'h0;

  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len == '0)                w_next = DONE;
          else if (len > LEN_W'(12))    w_next = LOAD;
          else                          w_next = TAIL;
        end
      end
      LOAD:  if (w_xfer && r_widx == 2'd2) w_next = MIX;
      MIX:   if (w_mix_last) w_next = (w_rem_dec > LEN_W'(12)) ? LOAD : TAIL;
      TAIL:  if (w_xfer && w_last_word) w_next = FINAL;
      FINAL: if (w_fin_last) w_next = DONE;
      DONE:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_a    <= 32'h0;
      r_b    <= 32'h0;
      r_c    <= 32'h0;
      r_rem  <= '0;
      r_widx <= 2'd0;
      r_rnd  <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= w_init;
            r_b    <= w_init;
            r_c    <= w_init;
            r_rem  <= len;
            r_widx <= 2'd0;
            r_rnd  <= 3'd0;
          end
        end
        LOAD, TAIL: begin
          // Words are folded into a/b/c as they arrive; absent tail words add 0.
          if (w_xfer) begin
            case (r_widx)
              2'd0:    r_a <= r_a + w_word;
              2'd1:    r_b <= r_b + w_word;
              default: r_c <= r_c + w_word;
            endcase
            if ((r_state == LOAD) ? (r_widx == 2'd2) : w_last_word) r_widx <= 2'd0;
            else                                                     r_widx <= r_widx + 2'd1;
          end
        end
        MIX: begin
          {r_a, r_b, r_c} <= w_mix_sel;
          if (w_mix_last) begin
            r_rnd <= 3'd0;
            r_rem <= w_rem_dec;
          end else begin
            r_rnd <= r_rnd + 3'd1;
          end
        end
        FINAL: begin
          {r_a, r_b, r_c} <= w_fin_sel;
          if (w_fin_last) r_rnd <= 3'd0;
          else            r_rnd <= r_rnd + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lookup3_hash.sv
// tb/tb_lookup3_hash.sv - random and known-answer bench for lookup3_hash (both UNROLL builds)
module tb_lookup3_hash;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             res;
  logic             start     [2];
  logic [LEN_W-1:0] len       [2];
  logic [31:0]      initval   [2];
  logic             in_valid  [2];
  logic [31:0]      in_data   [2];
  logic             in_ready  [2];
  logic             busy      [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [31:0]      out_hash  [2];

  // Index 0 is the round-per-cycle build, index 1 the fully unrolled build.
  lookup3_hash #(.LEN_W(LEN_W), .UNROLL(0)) u_dut0 (
    .clk(clk), .res(res), .start(start[0]), .len(len[0]), .initval(initval[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .busy(busy[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_hash(out_hash[0])
  );

  lookup3_hash #(.LEN_W(LEN_W), .UNROLL(1)) u_dut1 (
    .clk(clk), .res(res), .start(start[1]), .len(len[1]), .initval(initval[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .busy(busy[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_hash(out_hash[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned msg [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // Little-endian word at byte offset i with bytes at or past n read as zero.
  function automatic logic [31:0] kword(input int i, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < 4; j++)
      if (i + j < n) w = w | (32'(msg[i + j]) << (8 * j));
    return w;
  endfunction

  // Software hashlittle over msg[0..n-1].
  function automatic logic [31:0] ref_hash(input int n, input logic [31:0] iv);
    logic [31:0] a, b, c;
    int l, p;
    a = 32'hDEADBEEF + 32'(n) + iv;
    b = a;
    c = a;
    l = n;
    p = 0;
    while (l > 12) begin
      a += kword(p, n); b += kword(p + 4, n); c += kword(p + 8, n);
      a -= c; a ^= rotl(c, 4);  c += b;
      b -= a; b ^= rotl(a, 6);  a += c;
      c -= b; c ^= rotl(b, 8);  b += a;
      a -= c; a ^= rotl(c, 16); c += b;
      b -= a; b ^= rotl(a, 19); a += c;
      c -= b; c ^= rotl(b, 4);  b += a;
      l -= 12;
      p += 12;
    end
    if (l == 0) return c;
    a += kword(p, n); b += kword(p + 4, n); c += kword(p + 8, n);
    c ^= b; c -= rotl(b, 14);
    a ^= c; a -= rotl(c, 11);
    b ^= a; b -= rotl(a, 25);
    c ^= b; c -= rotl(b, 16);
    a ^= c; a -= rotl(c, 4);
    b ^= a; b -= rotl(a, 14);
    c ^= b; c -= rotl(b, 24);
    return c;
  endfunction

  // Raw word as streamed: bytes past the message carry whatever msg holds.
  function automatic logic [31:0] raw_word(input int w);
    return {msg[4*w+3], msg[4*w+2], msg[4*w+1], msg[4*w]};
  endfunction

  // Cycles from the first negedge after start to out_valid with no input gaps.
  function automatic int exp_lat(input int d, input int n);
    int nmix;
    if (n == 0) return 0;
    nmix = (n > 12) ? (n - 1) / 12 : 0;
    return (n + 3) / 4 + nmix * ((d != 0) ? 1 : 6) + ((d != 0) ? 1 : 7);
  endfunction

  function automatic void load_fourscore();
    string s;
    s = "Four score and seven years ago";
    for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
    for (int i = 0; i < 30; i++) msg[i] = s[i];
  endfunction

  task automatic run_hash(input int d, input int n, input logic [31:0] iv, input int gap_pct,
                          input int hold, input bit spam,
                          output logic [31:0] h, output int nxfer, output int lat);
    logic rdy;
    h = 32'h0;
    nxfer = 0;
    lat = 0;
    @(negedge clk);
    start[d]   = 1'b1;
    len[d]     = LEN_W'(n);
    initval[d] = iv;
    @(negedge clk);
    start[d] = 1'b0;
    while (1) begin
      if (out_valid[d] || lat >= 4000) break;
      in_valid[d] = ($urandom_range(99) >= gap_pct);
      in_data[d]  = (nxfer < 60) ? raw_word(nxfer) : $urandom;
      // Starts raised while busy must be ignored.
      start[d]   = spam ? 1'($urandom_range(1)) : 1'b0;
      len[d]     = LEN_W'($urandom);
      initval[d] = $urandom;
      rdy = in_ready[d];
      @(negedge clk);
      if (in_valid[d] && rdy) nxfer++;
      lat++;
    end
    in_valid[d] = 1'b0;
    start[d]    = 1'b0;
    if (!out_valid[d]) begin
      chk("out_valid_timeout", 32'(out_valid[d]), 32'd1);
      return;
    end
    h = out_hash[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_hash_stable", out_hash[d], h);
      chk("hold_valid", 32'(out_valid[d]), 32'd1);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk("valid_clear", 32'(out_valid[d]), 32'd0);
    chk("busy_clear", 32'(busy[d]), 32'd0);
  endtask

  task automatic reset_mid_mix(input int d);
    logic [31:0] h;
    int nx, lat, guard;
    logic rdy;
    load_fourscore();
    @(negedge clk);
    start[d]   = 1'b1;
    len[d]     = LEN_W'(30);
    initval[d] = 32'h0;
    @(negedge clk);
    start[d] = 1'b0;
    nx = 0;
    guard = 0;
    while (nx < 3 && guard < 50) begin
      in_valid[d] = 1'b1;
      in_data[d]  = raw_word(nx);
      rdy = in_ready[d];
      @(negedge clk);
      if (rdy) nx++;
      guard++;
    end
    in_valid[d] = 1'b0;
    chk("mix_in_ready", 32'(in_ready[d]), 32'd0);
    chk("mix_busy", 32'(busy[d]), 32'd1);
    res = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_in_ready", 32'(in_ready[d]), 32'd0);
    chk("rst_out_hash", out_hash[d], 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_valid", 32'(out_valid[d]), 32'd0);
    end
    res = 1'b1;
    run_hash(d, 30, 32'h1, 0, 0, 1'b0, h, nx, lat);
    chk("post_reset_hash", h, 32'hCD628161);
  endtask

  initial begin
    logic [31:0] h, iv;
    int nx, lat, n, gap;

    res = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; len[d] = '0; initval[d] = 32'h0;
      in_valid[d] = 1'b0; in_data[d] = 32'h0; out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_out_valid", 32'(out_valid[d]), 32'd0);
      chk("reset_busy", 32'(busy[d]), 32'd0);
      chk("reset_in_ready", 32'(in_ready[d]), 32'd0);
      chk("reset_out_hash", out_hash[d], 32'd0);
    end
    res = 1'b1;

    for (int d = 0; d < 2; d++) begin
      run_hash(d, 0, 32'h0, 0, 0, 1'b0, h, nx, lat);
      chk("len0_iv0", h, 32'hDEADBEEF);
      chk("len0_lat", 32'(lat), 32'd0);
      chk("len0_words", 32'(nx), 32'd0);
      run_hash(d, 0, 32'hDEADBEEF, 0, 1, 1'b0, h, nx, lat);
      chk("len0_ivdeadbeef", h, 32'hBD5B7DDE);

      load_fourscore();
      run_hash(d, 30, 32'h0, 0, 0, 1'b0, h, nx, lat);
      chk("fourscore_iv0", h, 32'h17770551);
      chk("fourscore_words", 32'(nx), 32'd8);
      chk("fourscore_lat", 32'(lat), 32'(exp_lat(d, 30)));
      run_hash(d, 30, 32'h1, 0, 0, 1'b0, h, nx, lat);
      chk("fourscore_iv1", h, 32'hCD628161);
      run_hash(d, 30, 32'h0, 40, 5, 1'b1, h, nx, lat);
      chk("fourscore_gaps_hold", h, 32'h17770551);
      chk("fourscore_gaps_words", 32'(nx), 32'd8);

      for (int len_i = 1; len_i <= 25; len_i++) begin
        for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
        iv  = $urandom;
        gap = (len_i % 2 == 1) ? 30 : 0;
        run_hash(d, len_i, iv, gap, $urandom_range(0, 3), gap != 0, h, nx, lat);
        chk($sformatf("rand_len%0d_hash", len_i), h, ref_hash(len_i, iv));
        chk($sformatf("rand_len%0d_words", len_i), 32'(nx), 32'((len_i + 3) / 4));
        if (gap == 0) chk($sformatf("rand_len%0d_lat", len_i), 32'(lat), 32'(exp_lat(d, len_i)));
      end

      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
        n  = $urandom_range(26, 150);
        iv = $urandom;
        run_hash(d, n, iv, 25, 1, 1'b1, h, nx, lat);
        chk($sformatf("long_len%0d_hash", n), h, ref_hash(n, iv));
        chk($sformatf("long_len%0d_words", n), 32'(nx), 32'((n + 3) / 4));
      end

      reset_mid_mix(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lookup3_hash.md
LOOKUP3_HASH -- requirements
Module: lookup3_hash

Interface
REQ-001 Parameter LEN_W, default 16; width of the byte-length input (max message 2^LEN_W-1 bytes).
REQ-002 Parameter UNROLL, default 1; 1 = whole mix or final in one cycle, 0 = one rotate/add round per cycle.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port res  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request a new hash; accepted only when busy=0.
REQ-006 Port len  input  LEN_W  message length in bytes, sampled with an accepted start.
REQ-007 Port initval  input  32  seed, sampled with an accepted start.
REQ-008 Port in_valid  input  1  in_data holds a valid message word.
REQ-009 Port in_data  input  32  message word, little-endian: message byte n of word is bits [8n+7:8n].
REQ-010 Port in_ready  output  1  block accepts in_data this cycle.
REQ-011 Port busy  output  1  a hash is in progress or its result is not yet taken.
REQ-012 Port out_valid  output  1  out_hash valid; held until out_ready.
REQ-013 Port out_ready  input  1  consumer takes out_hash.
REQ-014 Port out_hash  output  32  Jenkins lookup3 hashlittle result (value c).

Function
REQ-015 The start handshake SHALL complete when start=1 and busy=0; a start while busy=1 SHALL be ignored.
REQ-016 On an accepted start, a, b and c SHALL each be loaded with 32'hDEADBEEF + len (zero-extended) + initval, modulo 2^32.
REQ-017 Exactly ceil(len/4) words SHALL be accepted, each transferring when in_valid=1 and in_ready=1; in_ready SHALL be 0 outside states LOAD and TAIL.
REQ-018 States SHALL be: IDLE, LOAD, MIX, TAIL, FINAL, DONE.
REQ-019 IDLE -> LOAD on start with len>12; IDLE -> TAIL on start with 1<=len<=12; IDLE -> DONE on start with len=0.
REQ-020 LOAD SHALL accept 3 words k0,k1,k2 and add them to a,b,c respectively, then go to MIX.
REQ-021 MIX SHALL apply the lookup3 mix (rotations 4,6,8,16,19,4) and decrement the remaining count by 12; the next state SHALL be LOAD if remaining >12, otherwise TAIL.
REQ-022 TAIL SHALL accept ceil(remaining/4) words; absent words SHALL be 0, and bytes of the last word beyond remaining SHALL be masked to 0 regardless of in_data.
REQ-023 After the last tail word, a+=k0, b+=k1 and c+=k2 SHALL be applied, then the state SHALL go to FINAL.
REQ-024 FINAL SHALL apply the lookup3 final (rotations 14,11,25,16,4,14,24), then go to DONE.
REQ-025 In DONE, out_hash SHALL equal c and out_valid=1; on out_ready=1, out_valid SHALL clear and the state SHALL go to IDLE in the same edge.
REQ-026 For len=0, the final SHALL be skipped and out_hash SHALL be the initial c, with out_valid=1 on the cycle after start.
REQ-027 With UNROLL=1, MIX and FINAL SHALL each take 1 cycle; with UNROLL=0, MIX SHALL take 6 cycles and FINAL 7 cycles.
REQ-028 All additions, subtractions and rotations SHALL be 32-bit modulo 2^32; rot(x,k) = (x<<k)|(x>>(32-k)).
REQ-029 Input stalls (in_valid=0) SHALL only delay the hash and SHALL NOT change the result; out_valid held without out_ready SHALL keep out_hash stable.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 While res=0, the state SHALL be IDLE, a, b, c and the remaining count SHALL be 0, out_hash SHALL be 0, and out_valid, in_ready and busy SHALL be 0.
REQ-032 Reset asserted mid-hash SHALL abort the hash with no output; after release the block SHALL accept a new start.

Verification
REQ-033 start with len=0, initval=0 -> out_hash=32'hDEADBEEF one cycle later.
REQ-034 start with len=0, initval=32'hDEADBEEF -> out_hash=32'hBD5B7DDE.
REQ-035 "Four score and seven years ago" (len=30, 8 words), initval=0 -> 32'h17770551; initval=1 -> 32'hCD628161; check both UNROLL values.
REQ-036 Same 30-byte message with random in_valid gaps and out_ready held low 5 cycles -> identical hash, and out_hash stable while held.
REQ-037 Lengths 1..25, random data and seed -> results match a software hashlittle model; exactly ceil(len/4) words consumed.
REQ-038 res pulsed low during MIX -> no out_valid; the next hash starting 1 cycle after release is correct.
